// File: rtl/audio_gain_ramp.sv
// audio_gain_ramp: per-sample gain ramp (Q1.7) with a 3-stage multiply/saturate pipeline and mute fade
module audio_gain_ramp #(
  parameter int DW = 24,
  parameter int GW = 8,
  parameter int RAMP_STEP = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          sample_clk_i,
  input  logic [DW-1:0] sample_i,
  input  logic [GW-1:0] gain_target_i,
  input  logic          mute_i,
  output logic [DW-1:0] sample_o,
  output logic          sample_valid_o,
  output logic          clip_o,
  output logic [GW-1:0] gain_cur_o,
  output logic          ramp_busy_o,
  output logic          muted_o
);
  localparam int PW = DW + GW + 1;
  localparam logic [GW-1:0] STEP = GW'(RAMP_STEP);
  typedef enum logic [1:0] {MUTED, STEADY, RAMP_UP, RAMP_DOWN} state_t;
  state_t state_q, state_d;
  logic sclk_q, v1_q, v2_q, valid_q, clip_q, ev, sat_hi, sat_lo;
  logic signed [DW-1:0] s1_q, out_q, sat;
  logic signed [PW-1:0] prod_q, shifted;
  logic [GW-1:0] gain_q, gain_d, eff, up_diff, dn_diff;
  assign ev = sample_clk_i & ~sclk_q & en_i;
  assign eff = mute_i ? '0 : gain_target_i;
  assign up_diff = eff - gain_q;
  assign dn_diff = gain_q - eff;
  always_comb begin
    gain_d = gain_q;
    if (ev)
      gain_d = (gain_q < eff) ? gain_q + ((up_diff > STEP) ? STEP : up_diff) :
               (gain_q > eff) ? gain_q - ((dn_diff > STEP) ? STEP : dn_diff) : gain_q;
  end
  always_comb begin
    state_d = state_q;
    if (en_i)
      state_d = (gain_d < eff) ? RAMP_UP :
                (gain_d > eff) ? RAMP_DOWN :
                (mute_i && gain_d == '0) ? MUTED : STEADY;
  end
  // overflow whenever the bits above the DW-1 sign position disagree
  assign shifted = prod_q >>> 7;
  assign sat_hi = ~shifted[PW-1] & |shifted[PW-1:DW-1];
  assign sat_lo = shifted[PW-1] & ~&shifted[PW-1:DW-1];
  assign sat = sat_hi ? {1'b0, {(DW-1){1'b1}}} :
               sat_lo ? {1'b1, {(DW-1){1'b0}}} : shifted[DW-1:0];
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= MUTED;
    else if (en_i) state_q <= state_d;
  end
  always_ff @(posedge clk_i) begin
    sclk_q <= rst_i ? 1'b0 : sample_clk_i;
    if (rst_i) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      valid_q <= 1'b0;
      clip_q <= 1'b0;
      s1_q <= '0;
      prod_q <= '0;
      out_q <= '0;
      gain_q <= '0;
    end else begin
      valid_q <= en_i & v2_q;
      if (en_i) begin
        v1_q <= ev;
        v2_q <= v1_q;
        gain_q <= gain_d;
        if (ev) s1_q <= sample_i;
        if (v1_q) prod_q <= PW'(s1_q) * PW'($signed({1'b0, gain_q}));
        if (v2_q) begin
          out_q <= sat;
          clip_q <= sat_hi | sat_lo;
        end
      end
    end
  end
  assign sample_o = out_q;
  assign sample_valid_o = valid_q;
  assign clip_o = clip_q;
  assign gain_cur_o = gain_q;
  assign ramp_busy_o = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
  assign muted_o = state_q == MUTED;
endmodule

// File: tb/tb_audio_gain_ramp.sv
// tb_audio_gain_ramp: directed vector table and corner sequences plus random stimulus against an event-level model
module tb_audio_gain_ramp;
  localparam int RS = 1;
  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b1, sclk = 1'b0, mute = 1'b0;
  logic [23:0] sin = '0;
  logic [7:0] tgt = '0;
  logic [23:0] sout;
  logic [7:0] gcur;
  logic valid, clip, busy, muted;
  int checks = 0, failures = 0;
  int m_gain;
  longint m_out;
  bit m_sclk, m_valid, m_clip, m_busy, m_muted;
  typedef struct {int rem; longint val; bit clip;} pend_t;
  pend_t pend[$];
  typedef struct {logic [7:0] g; logic [23:0] s; logic [23:0] o; bit c;} vec_t;
  vec_t tab[8];
  bit seen, seen_clip;
  logic [23:0] seen_out;
  int pulses;

  always #5 clk = ~clk;

  audio_gain_ramp dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .sample_clk_i(sclk), .sample_i(sin),
    .gain_target_i(tgt), .mute_i(mute), .sample_o(sout), .sample_valid_o(valid),
    .clip_o(clip), .gain_cur_o(gcur), .ramp_busy_o(busy), .muted_o(muted)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // model: one step per clock; a sample taken at an event appears after two further enabled edges
  task automatic step();
    int eff;
    bit ev;
    longint p, q;
    bit c;
    @(posedge clk);
    if (rst) begin
      m_gain = 0; m_out = 0; m_valid = 0; m_clip = 0; m_busy = 0; m_muted = 1;
      pend.delete();
    end else begin
      m_valid = 0;
      if (en) begin
        eff = mute ? 0 : int'(tgt);
        ev = sclk && !m_sclk;
        for (int i = 0; i < pend.size(); i++) pend[i].rem--;
        if (pend.size() > 0 && pend[0].rem == 0) begin
          m_valid = 1; m_out = pend[0].val; m_clip = pend[0].clip;
          void'(pend.pop_front());
        end
        if (ev) begin
          if (eff > m_gain) m_gain += (eff - m_gain < RS) ? eff - m_gain : RS;
          else if (eff < m_gain) m_gain -= (m_gain - eff < RS) ? m_gain - eff : RS;
          p = longint'($signed(sin)) * m_gain;
          q = p / 128;
          if (p < 0 && (p % 128) != 0) q--;
          c = 0;
          if (q > 8388607) begin q = 8388607; c = 1; end
          if (q < -8388608) begin q = -8388608; c = 1; end
          pend.push_back('{2, q, c});
        end
        m_busy = m_gain != eff;
        m_muted = (m_gain == eff) && mute && (m_gain == 0);
      end
    end
    m_sclk = rst ? 1'b0 : sclk;
    #1;
    if (valid) begin
      pulses++; seen = 1; seen_out = sout; seen_clip = clip;
    end
    check("valid", valid, m_valid);
    check("sample_o", sout, m_out & 64'hFFFFFF);
    check("clip", clip, m_clip);
    check("gain_cur", gcur, m_gain);
    check("busy", busy, m_busy);
    check("muted", muted, m_muted);
  endtask

  task automatic pulse(input logic [23:0] s);
    sin = s; sclk = 1'b1; step();
    sclk = 1'b0; step(); step(); step();
  endtask

  task automatic run_until(input int g, output int n);
    n = 0;
    while (m_gain != g && n < 400) begin
      pulse($urandom);
      n++;
    end
    check("reach_gain", gcur, g);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int n, pos;
    tab[0] = '{8'd128, 24'h123456, 24'h123456, 1'b0};
    tab[1] = '{8'd128, 24'h800000, 24'h800000, 1'b0};
    tab[2] = '{8'd255, 24'h400000, 24'h7F8000, 1'b0};
    tab[3] = '{8'd255, 24'h7FFFFF, 24'h7FFFFF, 1'b1};
    tab[4] = '{8'd255, 24'h800000, 24'h800000, 1'b1};
    tab[5] = '{8'd129, 24'h7FFFFF, 24'h7FFFFF, 1'b1};
    tab[6] = '{8'd64,  24'hFFFFFD, 24'hFFFFFE, 1'b0};
    tab[7] = '{8'd0,   24'h7FFFFF, 24'h000000, 1'b0};
    step(); step();
    check("rst_gain", gcur, 0);
    check("rst_muted", muted, 1);
    check("rst_busy", busy, 0);
    check("rst_out", sout, 0);
    rst = 1'b0;
    tgt = 8'd128;
    step();
    check("fadein_busy", busy, 1);
    run_until(128, n);
    check("fadein_events", n, 128);
    check("steady_busy", busy, 0);
    check("steady_muted", muted, 0);
    for (int i = 0; i < 8; i++) begin
      tgt = tab[i].g;
      run_until(int'(tab[i].g), n);
      seen = 0;
      pulse(tab[i].s);
      check("tab_seen", seen, 1);
      check("tab_out", seen_out, tab[i].o);
      check("tab_clip", seen_clip, tab[i].c);
    end
    tgt = 8'd128;
    run_until(128, n);
    mute = 1'b1;
    run_until(40, n);
    check("mute_to40_events", n, 88);
    check("mute_busy", busy, 1);
    mute = 1'b0;
    pulse(24'h000100);
    check("redirect_up", gcur, 41);
    check("redirect_busy", busy, 1);
    mute = 1'b1;
    run_until(0, n);
    check("mute_to0_events", n, 41);
    check("muted_flag", muted, 1);
    seen = 0;
    pulse(24'h123456);
    check("muted_out", seen_out, 0);
    mute = 1'b0;
    tgt = 8'd100;
    repeat (10) pulse($urandom);
    pulses = 0; pos = -1;
    sin = 24'h010000; sclk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (valid && pos < 0) pos = i;
    end
    sclk = 1'b0;
    repeat (4) step();
    check("held_pulses", pulses, 1);
    check("held_pos", pos, 2);
    pulses = 0;
    en = 1'b0; sclk = 1'b1;
    repeat (3) step();
    en = 1'b1;
    repeat (3) step();
    sclk = 1'b0;
    repeat (4) step();
    check("dis_rise_pulses", pulses, 0);
    pulses = 0;
    sin = 24'h020000; sclk = 1'b1; step();
    sclk = 1'b0; en = 1'b0;
    repeat (4) step();
    check("stall_pulses", pulses, 0);
    en = 1'b1;
    repeat (3) step();
    check("stall_resume", pulses, 1);
    pulses = 0;
    sin = 24'h300000; sclk = 1'b1; step();
    sclk = 1'b0; rst = 1'b1; step();
    rst = 1'b0;
    check("midrst_gain", gcur, 0);
    check("midrst_out", sout, 0);
    check("midrst_muted", muted, 1);
    repeat (4) step();
    check("midrst_pulses", pulses, 0);
    for (int it = 0; it < 400; it++) begin
      tgt = 8'($urandom);
      mute = ($urandom_range(0, 9) == 0);
      sin = 24'($urandom);
      en = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 99) == 0);
      sclk = 1'b1;
      repeat ($urandom_range(1, 3)) step();
      sclk = 1'b0; rst = 1'b0;
      en = ($urandom_range(0, 7) != 0);
      repeat ($urandom_range(2, 4)) step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
